dac_word_sequencer: RTL and testbench

- Waveform playback buffer directly upstream of the DAC shifter stage.
- Stores up to `depth` 256-bit DAC words (16 samples x 16 bits each) written from the control side.
- On a start pulse, streams a programmed number of words back-to-back into the shifter's `dac_word_in`, optionally repeating.
- Latches the shift amount at start so the shifter sees a constant shift for a whole playback.

---
 rtl/dac_word_sequencer.sv | 154 +++++++++++++++
 tb/tb_dac_word_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_word_sequencer.sv
// Waveform playback buffer feeding the DAC shifter stage.
// Stores depth x stage_width words and streams them out on start, optionally repeating.
//
// Ports:
//   clk, rst        : system clock, async active-high reset
//   wr_en/addr/data : control-side write port into the waveform memory
//   start, abort    : playback request pulse / immediate stop (abort wins)
//   play_len        : words per pass (1..depth), sampled at start
//   repeats         : pass count, 0 = continuous until abort, sampled at start
//   shift_in        : shift amount, sampled at start
//   dac_word_out    : streamed word, zero whenever word_valid is low
//   shift_amt       : shift latched at start, stable for the whole stream
//   word_valid      : dac_word_out carries a stored word
//   busy            : playback accepted and final word not yet gone
//   done            : one-cycle pulse with the last valid word
module dac_word_sequencer #(
  parameter int stage_width = 256,
  parameter int depth       = 64,
  parameter int addr_w      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [addr_w-1:0]      wr_addr,
  input  logic [stage_width-1:0] wr_data,
  input  logic                   start,
  input  logic                   abort,
  input  logic [addr_w:0]        play_len,
  input  logic [7:0]             repeats,
  input  logic [7:0]             shift_in,
  output logic [stage_width-1:0] dac_word_out,
  output logic [7:0]             shift_amt,
  output logic                   word_valid,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DRAIN
  } state_t;

  localparam logic [addr_w:0] DepthV = (addr_w+1)'(depth);

  state_t                 state_q;
  logic [addr_w-1:0]      rd_addr_q;
  logic [7:0]             pass_cnt_q;
  logic [addr_w:0]        len_q;
  logic [7:0]             rep_q;
  logic                   rd_vld_q;
  logic                   rd_last_q;
  logic [stage_width-1:0] rd_data_q;
  logic [stage_width-1:0] mem_q [depth];

  logic                   start_ok_d;
  logic                   pass_end_d;
  logic                   last_pass_d;
  logic [7:0]             pass_inc_d;

  // Memory: write port plus registered read-first read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr_q];
  end

  always_comb begin
    start_ok_d  = start && (play_len != '0) && (play_len <= DepthV);
    pass_end_d  = ({1'b0, rd_addr_q} == (len_q - 1'b1));
    // repeats==0 never has a last pass: continuous playback
    last_pass_d = (rep_q != 8'd0) && (pass_cnt_q == (rep_q - 8'd1));
    pass_inc_d  = (pass_cnt_q == 8'hFF) ? pass_cnt_q
                                        : pass_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      pass_cnt_q   <= '0;
      len_q        <= '0;
      rep_q        <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      dac_word_out <= '0;
      shift_amt    <= '0;
      word_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort) begin
      // drop everything in flight; shift_amt is kept
      state_q      <= IDLE;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      dac_word_out <= '0;
      word_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // output stage: one cycle behind the memory read
      word_valid   <= rd_vld_q;
      done         <= rd_vld_q && rd_last_q;
      dac_word_out <= rd_vld_q ? rd_data_q : '0;

      unique case (state_q)
        IDLE: begin
          rd_vld_q  <= 1'b0;
          rd_last_q <= 1'b0;
          if (start_ok_d) begin
            state_q    <= PLAY;
            len_q      <= play_len;
            rep_q      <= repeats;
            shift_amt  <= shift_in;
            rd_addr_q  <= '0;
            pass_cnt_q <= '0;
            busy       <= 1'b1;
          end
        end
        PLAY: begin
          rd_vld_q  <= 1'b1;
          rd_last_q <= 1'b0;
          if (pass_end_d) begin
            rd_addr_q <= '0;
            if (last_pass_d) begin
              state_q   <= DRAIN;
              rd_last_q <= 1'b1;
            end else begin
              pass_cnt_q <= pass_inc_d;
            end
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          rd_vld_q  <= 1'b0;
          rd_last_q <= 1'b0;
          // last read has reached the output register
          if (!rd_vld_q) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rd_vld_q <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_word_sequencer.sv
// Directed testbench for dac_word_sequencer.
// Linear stimulus; outputs sampled on the falling clock edge.
module tb_dac_word_sequencer;

  localparam int SW = 256;
  localparam int DP = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [SW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   play_len = '0;
  logic [7:0]    repeats = '0;
  logic [7:0]    shift_in = '0;
  logic [SW-1:0] dac_word_out;
  logic [7:0]    shift_amt;
  logic          word_valid;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_word_sequencer #(
    .stage_width(SW),
    .depth(DP),
    .addr_w(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .abort(abort),
    .play_len(play_len),
    .repeats(repeats),
    .shift_in(shift_in),
    .dac_word_out(dac_word_out),
    .shift_amt(shift_amt),
    .word_valid(word_valid),
    .busy(busy),
    .done(done)
  );

  function automatic logic [SW-1:0] w(input int k);
    logic [15:0] s;
    s = 16'h00A0 + 16'(k);
    return {16{s}};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [SW-1:0] obs,
                     input logic [SW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [SW-1:0] ew,
                      input logic ev, input logic ed, input logic eb);
    chk({tag, ".word"}, dac_word_out, ew);
    chk({tag, ".valid"}, SW'(word_valid), SW'(ev));
    chk({tag, ".done"}, SW'(done), SW'(ed));
    chk({tag, ".busy"}, SW'(busy), SW'(eb));
  endtask

  task automatic wr(input int a, input logic [SW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic go(input int len, input int rep, input int sh);
    start    = 1'b1;
    play_len = (AW+1)'(len);
    repeats  = 8'(rep);
    shift_in = 8'(sh);
    tick();
    start    = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    outs("rst", '0, 1'b0, 1'b0, 1'b0);
    chk("rst.shift", SW'(shift_amt), SW'(0));
    rst = 1'b0;
    for (int i = 0; i < DP; i++) wr(i, w(i));
    outs("idle", '0, 1'b0, 1'b0, 1'b0);

    // single pass
    go(4, 1, 5);
    chk("sp.shiftT", SW'(shift_amt), SW'(5));
    chk("sp.busyT", SW'(busy), SW'(1));
    tick();
    chk("sp.shiftT1", SW'(shift_amt), SW'(5));
    outs("sp.T1", '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      outs($sformatf("sp.w%0d", k), w(k), 1'b1, k == 3, 1'b1);
    end
    tick();
    outs("sp.end", '0, 1'b0, 1'b0, 1'b0);
    tick();
    outs("sp.idle", '0, 1'b0, 1'b0, 1'b0);

    // repeats + wrap, with an overlapping start ignored
    go(3, 2, 7);
    tick();
    outs("rp.T1", '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      outs($sformatf("rp.w%0d", k), w(k % 3), 1'b1, k == 5, 1'b1);
      chk($sformatf("rp.sh%0d", k), SW'(shift_amt), SW'(7));
      if (k == 1) begin
        start    = 1'b1;
        play_len = 7'd1;
        repeats  = 8'd1;
        shift_in = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    tick();
    outs("rp.end", '0, 1'b0, 1'b0, 1'b0);
    chk("rp.shend", SW'(shift_amt), SW'(7));

    // illegal starts and start+abort
    go(0, 1, 11);
    outs("il0.a", '0, 1'b0, 1'b0, 1'b0);
    tick();
    outs("il0.b", '0, 1'b0, 1'b0, 1'b0);
    go(65, 1, 11);
    outs("il65.a", '0, 1'b0, 1'b0, 1'b0);
    tick();
    outs("il65.b", '0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    go(4, 1, 12);
    abort = 1'b0;
    outs("sa.a", '0, 1'b0, 1'b0, 1'b0);
    tick();
    outs("sa.b", '0, 1'b0, 1'b0, 1'b0);
    chk("sa.shift", SW'(shift_amt), SW'(7));

    // continuous playback of the full memory, then abort
    go(DP, 0, 3);
    tick();
    outs("ct.T1", '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 200; k++) begin
      tick();
      outs($sformatf("ct.w%0d", k), w(k % DP), 1'b1, 1'b0, 1'b1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outs("ct.ab", '0, 1'b0, 1'b0, 1'b0);
    chk("ct.shift", SW'(shift_amt), SW'(3));
    tick();
    outs("ct.ab2", '0, 1'b0, 1'b0, 1'b0);

    // write collision on address 1 while it is being read
    go(4, 2, 4);
    tick();
    outs("wc.T1", '0, 1'b0, 1'b0, 1'b1);
    wr_en   = 1'b1;
    wr_addr = 6'd1;
    wr_data = {SW{1'b1}};
    tick();
    wr_en   = 1'b0;
    outs("wc.w0", w(0), 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 8; k++) begin
      tick();
      outs($sformatf("wc.w%0d", k),
           (k == 5) ? {SW{1'b1}} : w(k % 4), 1'b1, k == 7, 1'b1);
    end
    tick();
    outs("wc.end", '0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-stream
    go(8, 0, 6);
    for (int k = 0; k < 5; k++) tick();
    chk("ar.pre", SW'(word_valid), SW'(1));
    rst = 1'b1;
    #1;
    outs("ar.async", '0, 1'b0, 1'b0, 1'b0);
    chk("ar.shift", SW'(shift_amt), SW'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      outs($sformatf("ar.idle%0d", k), '0, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
